// File: rtl/any1_mem_seq.sv
// Load/store sequencer: walks 1..63 elements through AGEN -> BUS -> NEXT over a 64-bit bus.
// Optional bus timeout is enabled by defining ANY1_MEM_TIMEOUT_EN.
module any1_mem_seq #(
    parameter int AWID       = 32,
    parameter int TMO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [1:0]      size,
    input  logic [5:0]      vlen,
    input  logic [AWID-1:0] ea,
    input  logic [63:0]     st_data,
    output logic [5:0]      step,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [63:0]     ld_data,
    output logic            ld_valid,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [7:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [63:0]     dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [63:0]     dat_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AGEN = 3'd1;
    localparam logic [2:0] S_BUS  = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [5:0]      step_q, step_d;
    logic            store_q, store_d;
    logic [1:0]      size_q, size_d;
    logic [5:0]      vlen_q, vlen_d;
    logic            err_q, err_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [7:0]      sel_q, sel_d;
    logic [63:0]     dat_q, dat_d;
    logic [63:0]     ld_data_q, ld_data_d;
    logic            ld_valid_q, ld_valid_d;
    logic [6:0]      vmax;
    logic            tmo_hit;

    function automatic logic [7:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] data_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    data_mask = 64'h0000_0000_0000_00FF;
            2'd1:    data_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    data_mask = 64'h0000_0000_FFFF_FFFF;
            default: data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

`ifdef ANY1_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // A stalled bus cycle is aborted exactly like an err_i response.
    assign tmo_hit = (state_q == S_BUS) && !ack_i && !err_i
                     && (tmo_q == TMO_W'(TMO_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_AGEN) begin
            tmo_d = '0;
        end else if (state_q == S_BUS) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TMO_CYCLES != 0);
`endif

    // A vlen of 0 still performs one access.
    assign vmax = (vlen_q == 6'd0) ? 7'd1 : {1'b0, vlen_q};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        store_d    = store_q;
        size_d     = size_q;
        vlen_d     = vlen_q;
        err_d      = err_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    store_d = is_store;
                    size_d  = size;
                    vlen_d  = vlen;
                    step_d  = 6'd0;
                    state_d = S_AGEN;
                end
            end
            S_AGEN: begin
                adr_d   = ea;
                sel_d   = lane_mask(size_q) << ea[2:0];
                dat_d   = st_data << {ea[2:0], 3'b000};
                state_d = S_BUS;
            end
            S_BUS: begin
                if (err_i || tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (ack_i) begin
                    if (!store_q) begin
                        ld_data_d  = (dat_i >> {adr_q[2:0], 3'b000}) & data_mask(size_q);
                        ld_valid_d = 1'b1;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (({1'b0, step_q} + 7'd1) >= vmax) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 6'd1;
                    state_d = S_AGEN;
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_q     <= 6'd0;
            store_q    <= 1'b0;
            size_q     <= 2'd0;
            vlen_q     <= 6'd0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            sel_q      <= 8'd0;
            dat_q      <= 64'd0;
            ld_data_q  <= 64'd0;
            ld_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            store_q    <= store_d;
            size_q     <= size_d;
            vlen_q     <= vlen_d;
            err_q      <= err_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
        end
    end

    assign step     = step_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign fault    = (state_q == S_DONE) && err_q;
    assign cyc_o    = (state_q == S_BUS);
    assign stb_o    = (state_q == S_BUS);
    assign we_o     = (state_q == S_BUS) && store_q;
    assign sel_o    = sel_q;
    assign adr_o    = adr_q;
    assign dat_o    = dat_q;
    assign ld_data  = ld_data_q;
    assign ld_valid = ld_valid_q;

endmodule

// File: doc/any1_mem_seq.md
ANY1_MEM_SEQ -- requirements
Module: any1_mem_seq

Interface
REQ-001 Parameter AWID, default 32, address width of ea and adr_o.
REQ-002 Parameter TMO_CYCLES, default 255, bus timeout limit in cycles (timeout build only).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 is_store  input  1  1 = store, 0 = load; captured at start.
REQ-007 size  input  2  element size: 0 byte, 1 half, 2 word, 3 dword; captured at start.
REQ-008 vlen  input  6  element count; 0 or 1 = single scalar access; captured at start.
REQ-009 ea  input  AWID  effective address from address generator, registered, valid one cycle after step changes.
REQ-010 st_data  input  64  store data for the current element, sampled when stb_o first asserts.
REQ-011 step  output  6  element index driven to address generator.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 fault  output  1  one-cycle pulse with done when the sequence ended on error.
REQ-015 ld_data  output  64  load data, byte lanes right-justified and zero-extended by size.
REQ-016 ld_valid  output  1  one-cycle pulse per loaded element.
REQ-017 cyc_o, stb_o, we_o  output  1 each  bus cycle, strobe, write enable.
REQ-018 sel_o  output  8  byte lane selects; adr_o  output  AWID  bus address; dat_o  output  64  write data.
REQ-019 ack_i, err_i  input  1 each  bus acknowledge, bus error; dat_i  input  64  read data.

Function
REQ-020 States IDLE, AGEN, BUS, NEXT, DONE; the machine SHALL be one-hot or encoded, with no other reachable states.
REQ-021 IDLE: on start, capture controls, step<=0, go AGEN; otherwise stay.
REQ-022 AGEN: exactly one cycle, go BUS; adr_o<=ea, sel_o and dat_o computed from size and ea[2:0].
REQ-023 sel_o: size 0 -> 1 lane, 1 -> 2, 2 -> 4, 3 -> 8 lanes, shifted left by ea[2:0] with overflow bits beyond lane 7 dropped; dat_o = st_data shifted left 8*ea[2:0].
REQ-024 BUS: cyc_o=stb_o=1, we_o=is_store; adr_o, sel_o and dat_o are held stable until ack_i or err_i.
REQ-025 ack_i in BUS: drop stb_o/cyc_o next cycle; for loads ld_data<=dat_i shifted right 8*ea[2:0], masked by size, ld_valid pulses; go NEXT.
REQ-026 err_i in BUS (priority over simultaneous ack_i): drop bus, set error flag, go DONE with no ld_valid.
REQ-027 NEXT: if step+1 >= max(vlen,1) go DONE; else step<=step+1, go AGEN.
REQ-028 DONE: done=1 for one cycle, fault=error flag, clear flag, go IDLE; start in DONE is ignored.
REQ-029 Scalar load latency: start at cycle 0, stb_o at cycle 2, ack at cycle n gives ld_valid at n+1, done at n+2.
REQ-030 vlen=63 SHALL issue 63 accesses, step 0..62, without wrapping.
REQ-031 start while busy SHALL be ignored; in-flight inputs are not re-captured.

Reset
REQ-032 When rst is low: state IDLE, step 0, busy/done/fault/ld_valid 0, cyc_o/stb_o/we_o 0, sel_o 0, adr_o 0, dat_o 0, ld_data 0, error flag 0.
REQ-033 Reset mid-transaction SHALL drop cyc_o/stb_o immediately and abandon the sequence with no done pulse.

Configuration
REQ-034 Macro ANY1_MEM_TIMEOUT_EN defined: counter cleared on entering BUS, increments each BUS cycle; at TMO_CYCLES without ack_i/err_i, treat as err_i (REQ-026).
REQ-035 Macro ANY1_MEM_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; parameter TMO_CYCLES is unused.

Verification
REQ-036 Scalar load: size=2, ea=0x104, ack at 3rd BUS cycle, dat_i=0xAABBCCDD_11223344 -> sel_o=0xF0, ld_data=0xAABBCCDD, single done, fault=0.
REQ-037 Scalar store: size=0, ea=0x13, st_data=0x5A -> sel_o=0x08, dat_o[31:24]=0x5A, we_o=1, done 1 cycle after NEXT.
REQ-038 Vector load vlen=4, step-indexed ea -> step 0,1,2,3 in order, 4 ld_valid pulses, 4 bus cycles, one done.
REQ-039 err_i and ack_i together on element 2 of vlen=4 -> no further bus cycles, done=1 with fault=1, 2 ld_valid pulses total.
REQ-040 rst low while stb_o high -> cyc_o/stb_o low asynchronously, busy=0, no done; next start runs normally.
REQ-041 ANY1_MEM_TIMEOUT_EN, TMO_CYCLES=8, ack_i never -> fault and done after 8 BUS cycles; undefined build -> stb_o stays high.
